tx_packet_arbiter: RTL and testbench
====================================

Name: tx_packet_arbiter

Overview:
- Parametrised N-channel packet arbiter for the DoCE transaction-layer TX path.
- Merges the per-channel packet streams (aw, ar, r, b, barrier, plus future channels) into the single tx stream toward the network layer.
- Arbitrates at packet granularity, so a granted packet is never interleaved.
- One channel is strict-priority (the barrier channel). The rest share round-robin with fair pointer advance.
- A registered output stage carries data, keep, last, connection id and byte count.

Parameters:
- NUM_CH, 5, number of input channels (2..16).
- DATA_W, 128, beat data width in bits (multiple of 8).
- KEEP_W, DATA_W/8, byte-enable width.
- CONN_W, 4, connection id width.
- BYTE_W, 13, packet byte-count width.
- PRIO_CH, 0, index of the strict-priority channel; NUM_CH disables priority.
- CNT_W, 16, packet counter width (optional feature only).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- s_valid  in  NUM_CH  per-channel beat valid
- s_ready  out  NUM_CH  per-channel beat ready
- s_data  in  NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
- s_keep  in  NUM_CH*KEEP_W  byte enables, same slicing
- s_last  in  NUM_CH  end of packet
- s_conn_id  in  NUM_CH*CONN_W  destination connection id
- s_byte_num  in  NUM_CH*BYTE_W  packet byte count
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream ready
- m_data  out  DATA_W  output data
- m_keep  out  KEEP_W  output byte enables
- m_last  out  1  output end of packet
- m_conn_id  out  CONN_W  output connection id
- m_byte_num  out  BYTE_W  output byte count
- grant  out  NUM_CH  one-hot channel currently locked; 0 when idle
- stats_clr  in  1  synchronous clear of packet counters
- pkt_count  out  NUM_CH*CNT_W  per-channel completed-packet counters

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, on port reset.
- Values at reset:
  - m_valid, m_data, m_keep, m_last, m_conn_id, m_byte_num = 0.
  - grant = 0, s_ready = 0.
  - rr_ptr = NUM_CH-1, so channel 0 is the first round-robin candidate.
  - state = IDLE.
- FSM states: IDLE and LOCKED.
- IDLE:
  - If any s_valid is high, pick the winner and latch it into grant. The next state is LOCKED.
  - s_ready is 0 in IDLE.
  - This gives one arbitration bubble cycle per packet.
- Winner selection:
  - If PRIO_CH < NUM_CH and s_valid[PRIO_CH] is high, the winner is PRIO_CH. Priority suppresses all other channels.
  - Otherwise the winner is the first valid channel scanning from rr_ptr+1 upward, wrapping modulo NUM_CH.
- LOCKED:
  - s_ready[g] = (!m_valid | m_ready). All other s_ready bits are 0.
  - A beat is accepted when s_valid[g] and s_ready[g] are both high. It is registered into m_* the next cycle, with m_valid=1. Latency is 1 cycle.
  - Full throughput within a packet: one beat per cycle when m_ready stays high.
- End of packet: accepting a beat with s_last=1 returns the FSM to IDLE and clears grant.
  - rr_ptr takes the value g only if g != PRIO_CH. Priority packets do not disturb round-robin fairness.
- Output handshake:
  - When m_valid=1 and m_ready=0, every m_* output holds stable.
  - m_valid drops after m_ready when no new beat is accepted in that cycle.
- A packet in flight is never preempted, even if the priority channel becomes valid mid-packet.
- An s_valid gap mid-packet keeps the lock; the FSM waits.
- A packet of one beat with s_last=1 is legal. keep=0 beats pass through unchanged.
- conn_id and byte_num are sampled on every beat, not just the first.
- Reset mid-packet clears the lock and the output register immediately. The partially forwarded packet is dropped; resynchronising is the upstream's responsibility.

Optional Feature:
- Macro: TX_ARB_STATS_EN.
- Defined:
  - Each channel has a CNT_W counter that increments on acceptance of its s_last beat.
  - Counters wrap from all-ones to 0.
  - stats_clr=1 zeroes all counters. If stats_clr and an increment happen in the same cycle, the result is 0.
  - Reset value of all counters is 0.
- Undefined: pkt_count is tied to 0, stats_clr is ignored, and no counter flops exist. Ports are always present.

Decomposition:
- Package tx_arb_pkg holds:
  - default widths: DATA_W=128, CONN_W=4, BYTE_W=13.
  - the state typedef {IDLE, LOCKED}.
  - the channel index constants AW=4, AR=3, R=2, B=1, BARRIER=0.
- One combinational sub-module, tx_arb_rr_pick.
  - Inputs: NUM_CH request vector and rr_ptr.
  - Output: one-hot winner, plus an any-valid flag.

Test Plan:
- Single channel 2 sends 3 beats:
  - Stimulus: data 0x11, 0x22, 0x33, last on the third beat, conn_id=5, byte_num=48, m_ready=1.
  - Response: the m_* beats appear in order one cycle after acceptance. grant=5'b00100 for 3 cycles, then 0.
- Channels 1, 3 and 4 all hold 1-beat packets, no priority:
  - Response: grant order is 1, 3, 4, 1, 3, 4. Each packet is separated by one idle arbitration cycle.
- Priority preemption:
  - Stimulus: channel 3 is mid-packet (beat 2 of 4) when channel 0 (priority) raises valid.
  - Response: channel 3 finishes all 4 beats, then channel 0 wins over a pending channel 4. rr_ptr stays at 3, so channel 4 follows.
- Backpressure:
  - Stimulus: m_ready=0 for 5 cycles mid-packet.
  - Response: m_data is stable, s_ready[g]=0, and no beat is lost or duplicated once m_ready=1.
- Reset mid-packet:
  - Stimulus: assert reset asynchronously during beat 2.
  - Response: m_valid=0 and grant=0 immediately, and the next packet arbitrates from channel 0.
- TX_ARB_STATS_EN defined:
  - Stimulus: 3 packets on channel 1, then stats_clr coincident with a fourth last beat.
  - Response: pkt_count[1] reads 3, then 0.

Source files
------------

// File: rtl/tx_arb_pkg.sv
// ============================================================================
// Module      : tx_arb_pkg
// Description : Shared widths, channel indices and FSM encoding for the
//               DoCE TX packet arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tx_arb_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_CONN_W = 4;
  localparam int DEF_BYTE_W = 13;

  localparam int AW      = 4;
  localparam int AR      = 3;
  localparam int R       = 2;
  localparam int B       = 1;
  localparam int BARRIER = 0;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/tx_arb_rr_pick.sv
// ============================================================================
// Module      : tx_arb_rr_pick
// Description : Combinational round-robin picker; first request above the
//               pointer wins, wrapping modulo NUM_CH.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_arb_rr_pick
  import tx_arb_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int PTR_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [PTR_W-1:0]  i_ptr,
  output logic [NUM_CH-1:0] o_gnt,
  output logic              o_any
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_idx = PTR_W'((int'(i_ptr) + k) % NUM_CH);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

`default_nettype wire

// File: rtl/tx_packet_arbiter.sv
// ============================================================================
// Module      : tx_packet_arbiter
// Description : N-channel packet arbiter (strict-priority + round-robin) with
//               a registered output stage. Macro TX_ARB_STATS_EN adds
//               per-channel completed-packet counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_packet_arbiter
  import tx_arb_pkg::*;
#(
  parameter int NUM_CH  = 5,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int KEEP_W  = DATA_W / 8,
  parameter int CONN_W  = DEF_CONN_W,
  parameter int BYTE_W  = DEF_BYTE_W,
  parameter int PRIO_CH = 0,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          s_valid,
  output logic [NUM_CH-1:0]          s_ready,
  input  logic [NUM_CH*DATA_W-1:0]   s_data,
  input  logic [NUM_CH*KEEP_W-1:0]   s_keep,
  input  logic [NUM_CH-1:0]          s_last,
  input  logic [NUM_CH*CONN_W-1:0]   s_conn_id,
  input  logic [NUM_CH*BYTE_W-1:0]   s_byte_num,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W-1:0]          m_data,
  output logic [KEEP_W-1:0]          m_keep,
  output logic                       m_last,
  output logic [CONN_W-1:0]          m_conn_id,
  output logic [BYTE_W-1:0]          m_byte_num,
  output logic [NUM_CH-1:0]          grant,
  input  logic                       stats_clr,
  output logic [NUM_CH*CNT_W-1:0]    pkt_count
);

  localparam int PTR_W = $clog2(NUM_CH);
  // All-zero when PRIO_CH == NUM_CH, which disables the priority channel.
  localparam logic [NUM_CH-1:0] c_prio_onehot = NUM_CH'(1) << PRIO_CH;

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic [NUM_CH-1:0]   r_grant;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [NUM_CH-1:0]   w_rr_gnt;
  logic [NUM_CH-1:0]   w_win;
  logic                w_any;
  logic                w_prio_req;
  logic                w_out_free;
  logic                w_accept;
  logic                w_eop;

  logic [DATA_W-1:0]   w_sel_data;
  logic [KEEP_W-1:0]   w_sel_keep;
  logic                w_sel_last;
  logic [CONN_W-1:0]   w_sel_conn;
  logic [BYTE_W-1:0]   w_sel_bytes;
  logic [PTR_W-1:0]    w_gidx;

  logic                r_m_valid;
  logic [DATA_W-1:0]   r_m_data;
  logic [KEEP_W-1:0]   r_m_keep;
  logic                r_m_last;
  logic [CONN_W-1:0]   r_m_conn;
  logic [BYTE_W-1:0]   r_m_bytes;

  tx_arb_rr_pick #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_rr_pick (
    .i_req (s_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_rr_gnt),
    .o_any (w_any)
  );

  assign w_prio_req = |(s_valid & c_prio_onehot);
  assign w_win      = w_prio_req ? c_prio_onehot : w_rr_gnt;

  always_comb begin
    w_sel_data  = '0;
    w_sel_keep  = '0;
    w_sel_last  = 1'b0;
    w_sel_conn  = '0;
    w_sel_bytes = '0;
    w_gidx      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_grant[i]) begin
        w_sel_data  = s_data[i*DATA_W +: DATA_W];
        w_sel_keep  = s_keep[i*KEEP_W +: KEEP_W];
        w_sel_last  = s_last[i];
        w_sel_conn  = s_conn_id[i*CONN_W +: CONN_W];
        w_sel_bytes = s_byte_num[i*BYTE_W +: BYTE_W];
        w_gidx      = PTR_W'(i);
      end
    end
  end

  assign w_accept = |(s_valid & s_ready);
  assign w_eop    = w_accept & w_sel_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = LOCKED;
      LOCKED:  if (w_eop) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_out_free = !r_m_valid || m_ready;
    s_ready    = '0;
    if (r_state == LOCKED && w_out_free) s_ready = r_grant;
  end

  // Priority packets leave the round-robin pointer untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant  <= '0;
      r_rr_ptr <= PTR_W'(NUM_CH - 1);
    end else if (r_state == IDLE) begin
      r_grant <= w_win;
    end else if (w_eop) begin
      r_grant <= '0;
      if ((r_grant & c_prio_onehot) == '0) r_rr_ptr <= w_gidx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_keep  <= '0;
      r_m_last  <= 1'b0;
      r_m_conn  <= '0;
      r_m_bytes <= '0;
    end else if (w_accept) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_sel_data;
      r_m_keep  <= w_sel_keep;
      r_m_last  <= w_sel_last;
      r_m_conn  <= w_sel_conn;
      r_m_bytes <= w_sel_bytes;
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_keep     = r_m_keep;
  assign m_last     = r_m_last;
  assign m_conn_id  = r_m_conn;
  assign m_byte_num = r_m_bytes;
  assign grant      = r_grant;

`ifdef TX_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_stats
      logic [CNT_W-1:0] r_cnt;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)                       r_cnt <= '0;
        else if (stats_clr)              r_cnt <= '0;
        else if (w_eop && r_grant[gi])   r_cnt <= r_cnt + 1'b1;
      end
      assign pkt_count[gi*CNT_W +: CNT_W] = r_cnt;
    end
  endgenerate
`else
  logic w_unused_stats_clr;
  assign w_unused_stats_clr = stats_clr;
  assign pkt_count          = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tx_packet_arbiter.sv
// ============================================================================
// Module      : tb_tx_packet_arbiter
// Description : Directed self-checking bench for tx_packet_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tx_packet_arbiter;

  localparam int NUM_CH = 5;
  localparam int DATA_W = 128;
  localparam int KEEP_W = 16;
  localparam int CONN_W = 4;
  localparam int BYTE_W = 13;
  localparam int CNT_W  = 16;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_CH-1:0]         s_valid;
  logic [NUM_CH-1:0]         s_ready;
  logic [NUM_CH*DATA_W-1:0]  s_data;
  logic [NUM_CH*KEEP_W-1:0]  s_keep;
  logic [NUM_CH-1:0]         s_last;
  logic [NUM_CH*CONN_W-1:0]  s_conn_id;
  logic [NUM_CH*BYTE_W-1:0]  s_byte_num;
  logic                      m_valid;
  logic                      m_ready;
  logic [DATA_W-1:0]         m_data;
  logic [KEEP_W-1:0]         m_keep;
  logic                      m_last;
  logic [CONN_W-1:0]         m_conn_id;
  logic [BYTE_W-1:0]         m_byte_num;
  logic [NUM_CH-1:0]         grant;
  logic                      stats_clr;
  logic [NUM_CH*CNT_W-1:0]   pkt_count;

  int total = 0;
  int bad   = 0;

  tx_packet_arbiter #(
    .NUM_CH  (NUM_CH),
    .DATA_W  (DATA_W),
    .KEEP_W  (KEEP_W),
    .CONN_W  (CONN_W),
    .BYTE_W  (BYTE_W),
    .PRIO_CH (0),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_keep     (s_keep),
    .s_last     (s_last),
    .s_conn_id  (s_conn_id),
    .s_byte_num (s_byte_num),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_last     (m_last),
    .m_conn_id  (m_conn_id),
    .m_byte_num (m_byte_num),
    .grant      (grant),
    .stats_clr  (stats_clr),
    .pkt_count  (pkt_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic v, input logic [DATA_W-1:0] d,
                        input logic [KEEP_W-1:0] k, input logic l,
                        input logic [CONN_W-1:0] c, input logic [BYTE_W-1:0] n);
    s_valid[ch]                      = v;
    s_data[ch*DATA_W +: DATA_W]      = d;
    s_keep[ch*KEEP_W +: KEEP_W]      = k;
    s_last[ch]                       = l;
    s_conn_id[ch*CONN_W +: CONN_W]   = c;
    s_byte_num[ch*BYTE_W +: BYTE_W]  = n;
  endtask

  task automatic clear_inputs;
    s_valid    = '0;
    s_data     = '0;
    s_keep     = '0;
    s_last     = '0;
    s_conn_id  = '0;
    s_byte_num = '0;
    stats_clr  = 1'b0;
    m_ready    = 1'b1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    clear_inputs();
    s_valid = '1;
    tick();
    tick();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    total++; if (grant !== 5'b00000) begin bad++; $display("FAIL reset_grant: got %b want 00000", grant); end
    total++; if (s_ready !== 5'b00000) begin bad++; $display("FAIL reset_s_ready: got %b want 00000", s_ready); end
    total++; if (m_data !== 128'h0 || m_keep !== 16'h0 || m_last !== 1'b0)
      begin bad++; $display("FAIL reset_m_beat: got data=%h keep=%h last=%b want 0", m_data, m_keep, m_last); end
    total++; if (m_conn_id !== 4'h0 || m_byte_num !== 13'h0)
      begin bad++; $display("FAIL reset_m_meta: got conn=%h bytes=%h want 0", m_conn_id, m_byte_num); end
  endtask

  task automatic test_single;
    do_reset();
    set_ch(2, 1'b1, 128'h11, 16'hFFFF, 1'b0, 4'd5, 13'd48);
    tick();
    total++; if (grant !== 5'b00100) begin bad++; $display("FAIL single_arb_grant: got %b want 00100", grant); end
    total++; if (s_ready !== 5'b00100) begin bad++; $display("FAIL single_arb_ready: got %b want 00100", s_ready); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL single_arb_mvalid: got %b want 0", m_valid); end
    tick();
    total++; if (m_valid !== 1'b1 || m_data !== 128'h11 || m_keep !== 16'hFFFF || m_last !== 1'b0)
      begin bad++; $display("FAIL single_beat1: got v=%b d=%h k=%h l=%b want v=1 d=11 k=ffff l=0", m_valid, m_data, m_keep, m_last); end
    total++; if (m_conn_id !== 4'd5 || m_byte_num !== 13'd48)
      begin bad++; $display("FAIL single_beat1_meta: got conn=%0d bytes=%0d want 5 48", m_conn_id, m_byte_num); end
    total++; if (grant !== 5'b00100) begin bad++; $display("FAIL single_grant2: got %b want 00100", grant); end
    set_ch(2, 1'b1, 128'h22, 16'h0000, 1'b0, 4'd5, 13'd48);
    tick();
    total++; if (m_data !== 128'h22 || m_keep !== 16'h0000 || grant !== 5'b00100)
      begin bad++; $display("FAIL single_beat2: got d=%h k=%h g=%b want d=22 k=0000 g=00100", m_data, m_keep, grant); end
    set_ch(2, 1'b1, 128'h33, 16'h00FF, 1'b1, 4'd5, 13'd48);
    tick();
    total++; if (m_data !== 128'h33 || m_keep !== 16'h00FF || m_last !== 1'b1)
      begin bad++; $display("FAIL single_beat3: got d=%h k=%h l=%b want d=33 k=00ff l=1", m_data, m_keep, m_last); end
    total++; if (grant !== 5'b00000) begin bad++; $display("FAIL single_grant_end: got %b want 00000", grant); end
    s_valid[2] = 1'b0;
    tick();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got m_valid=%b want 0", m_valid); end
  endtask

  task automatic test_round_robin;
    int exp_ch [6];
    exp_ch = '{1, 3, 4, 1, 3, 4};
    do_reset();
    set_ch(1, 1'b1, 128'hA1, 16'hFFFF, 1'b1, 4'd1, 13'd16);
    set_ch(3, 1'b1, 128'hA3, 16'hFFFF, 1'b1, 4'd3, 13'd16);
    set_ch(4, 1'b1, 128'hA4, 16'hFFFF, 1'b1, 4'd4, 13'd16);
    for (int k = 0; k < 6; k++) begin
      tick();
      total++; if (grant !== (5'b00001 << exp_ch[k]))
        begin bad++; $display("FAIL rr_grant_%0d: got %b want ch%0d", k, grant, exp_ch[k]); end
      tick();
      total++; if (grant !== 5'b00000 || m_valid !== 1'b1 || m_last !== 1'b1 || m_data !== DATA_W'(32'hA0 + exp_ch[k]))
        begin bad++; $display("FAIL rr_beat_%0d: got g=%b v=%b l=%b d=%h want ch%0d", k, grant, m_valid, m_last, m_data, exp_ch[k]); end
    end
    s_valid = '0;
    tick();
  endtask

  task automatic test_priority;
    do_reset();
    set_ch(3, 1'b1, 128'h31, 16'hFFFF, 1'b0, 4'd3, 13'd64);
    tick();
    total++; if (grant !== 5'b01000) begin bad++; $display("FAIL prio_first_grant: got %b want 01000", grant); end
    tick();
    set_ch(3, 1'b1, 128'h32, 16'hFFFF, 1'b0, 4'd3, 13'd64);
    set_ch(0, 1'b1, 128'h01, 16'hFFFF, 1'b1, 4'd0, 13'd16);
    set_ch(4, 1'b1, 128'h41, 16'hFFFF, 1'b1, 4'd4, 13'd16);
    set_ch(1, 1'b1, 128'h1B, 16'hFFFF, 1'b1, 4'd1, 13'd16);
    #1;
    total++; if (s_ready !== 5'b01000) begin bad++; $display("FAIL prio_no_preempt_ready: got %b want 01000", s_ready); end
    tick();
    total++; if (grant !== 5'b01000 || m_data !== 128'h32)
      begin bad++; $display("FAIL prio_beat2: got g=%b d=%h want g=01000 d=32", grant, m_data); end
    set_ch(3, 1'b1, 128'h33, 16'hFFFF, 1'b0, 4'd3, 13'd64);
    tick();
    set_ch(3, 1'b1, 128'h34, 16'hFFFF, 1'b1, 4'd3, 13'd64);
    tick();
    total++; if (grant !== 5'b00000 || m_data !== 128'h34 || m_last !== 1'b1)
      begin bad++; $display("FAIL prio_ch3_done: got g=%b d=%h l=%b want g=0 d=34 l=1", grant, m_data, m_last); end
    s_valid[3] = 1'b0;
    tick();
    total++; if (grant !== 5'b00001) begin bad++; $display("FAIL prio_wins: got %b want 00001", grant); end
    tick();
    total++; if (m_data !== 128'h01) begin bad++; $display("FAIL prio_data: got %h want 01", m_data); end
    s_valid[0] = 1'b0;
    tick();
    total++; if (grant !== 5'b10000) begin bad++; $display("FAIL prio_rr_kept: got %b want 10000", grant); end
    tick();
    s_valid[4] = 1'b0;
    tick();
    total++; if (grant !== 5'b00010) begin bad++; $display("FAIL prio_rr_next: got %b want 00010", grant); end
    tick();
    total++; if (m_data !== 128'h1B) begin bad++; $display("FAIL prio_last_data: got %h want 1b", m_data); end
    s_valid = '0;
    tick();
  endtask

  task automatic test_backpressure;
    do_reset();
    set_ch(2, 1'b1, 128'h51, 16'hFFFF, 1'b0, 4'd1, 13'd64);
    tick();
    tick();
    set_ch(2, 1'b1, 128'h52, 16'hFFFF, 1'b0, 4'd2, 13'd64);
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (s_ready !== 5'b00000) begin bad++; $display("FAIL bp_ready_%0d: got %b want 00000", k, s_ready); end
      tick();
      total++; if (m_valid !== 1'b1 || m_data !== 128'h51 || m_conn_id !== 4'd1)
        begin bad++; $display("FAIL bp_hold_%0d: got v=%b d=%h c=%0d want v=1 d=51 c=1", k, m_valid, m_data, m_conn_id); end
    end
    m_ready = 1'b1;
    #1;
    total++; if (s_ready !== 5'b00100) begin bad++; $display("FAIL bp_release_ready: got %b want 00100", s_ready); end
    tick();
    total++; if (m_data !== 128'h52 || m_conn_id !== 4'd2)
      begin bad++; $display("FAIL bp_beat2: got d=%h c=%0d want d=52 c=2", m_data, m_conn_id); end
    s_valid[2] = 1'b0;
    tick();
    total++; if (m_valid !== 1'b0 || grant !== 5'b00100)
      begin bad++; $display("FAIL bp_gap: got v=%b g=%b want v=0 g=00100", m_valid, grant); end
    set_ch(2, 1'b1, 128'h53, 16'hFFFF, 1'b1, 4'd3, 13'd64);
    tick();
    total++; if (m_valid !== 1'b1 || m_data !== 128'h53 || m_last !== 1'b1 || m_conn_id !== 4'd3 || grant !== 5'b00000)
      begin bad++; $display("FAIL bp_beat3: got v=%b d=%h l=%b c=%0d g=%b want v=1 d=53 l=1 c=3 g=0", m_valid, m_data, m_last, m_conn_id, grant); end
    s_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid;
    do_reset();
    set_ch(3, 1'b1, 128'h61, 16'hFFFF, 1'b1, 4'd3, 13'd16);
    tick();
    tick();
    s_valid[3] = 1'b0;
    set_ch(2, 1'b1, 128'h71, 16'hFFFF, 1'b0, 4'd2, 13'd32);
    tick();
    tick();
    total++; if (m_valid !== 1'b1 || grant !== 5'b00100)
      begin bad++; $display("FAIL rstmid_pre: got v=%b g=%b want v=1 g=00100", m_valid, grant); end
    set_ch(2, 1'b1, 128'h72, 16'hFFFF, 1'b0, 4'd2, 13'd32);
    #2;
    reset = 1'b1;
    #1;
    total++; if (m_valid !== 1'b0 || grant !== 5'b00000 || s_ready !== 5'b00000 || m_data !== 128'h0)
      begin bad++; $display("FAIL rstmid_async: got v=%b g=%b r=%b d=%h want all 0", m_valid, grant, s_ready, m_data); end
    s_valid = '0;
    tick();
    reset = 1'b0;
    set_ch(1, 1'b1, 128'h81, 16'hFFFF, 1'b1, 4'd1, 13'd16);
    set_ch(4, 1'b1, 128'h84, 16'hFFFF, 1'b1, 4'd4, 13'd16);
    tick();
    total++; if (grant !== 5'b00010) begin bad++; $display("FAIL rstmid_rearb: got %b want 00010", grant); end
    tick();
    s_valid = '0;
    tick();
  endtask

  task automatic test_stats;
    logic [NUM_CH*CNT_W-1:0] exp_cnt;
    do_reset();
    set_ch(1, 1'b1, 128'h91, 16'hFFFF, 1'b1, 4'd1, 13'd16);
    repeat (6) tick();
    s_valid[1] = 1'b0;
`ifdef TX_ARB_STATS_EN
    exp_cnt = '0;
    exp_cnt[CNT_W +: CNT_W] = 16'd3;
    total++; if (pkt_count !== exp_cnt) begin bad++; $display("FAIL stats_three: got %h want %h", pkt_count, exp_cnt); end
    tick();
    s_valid[1] = 1'b1;
    tick();
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    s_valid = '0;
    exp_cnt = '0;
    total++; if (pkt_count !== exp_cnt) begin bad++; $display("FAIL stats_clr_collide: got %h want %h", pkt_count, exp_cnt); end
`else
    exp_cnt = '0;
    total++; if (pkt_count !== exp_cnt) begin bad++; $display("FAIL stats_tied_off: got %h want %h", pkt_count, exp_cnt); end
`endif
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_backpressure();
    test_reset_mid();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
